// File: rtl/commit_trace_fifo.sv
// ---------------------------------------------------------------------------
// commit_trace_fifo
//
// Captures the CPU retirement stream into an 8-entry circular FIFO and drains
// it to a debug/trace sink. Every commit is tagged with a 16-bit sequence
// number. The sequence counter advances on every retirement, including ones
// that are dropped, so a lost event shows up as a gap in traceSeq. A sticky
// overflow flag and a saturating drop counter also record lost events.
//
// Ports:
//   clk              system clock
//   globalReset      asynchronous, active-high reset
//   commitValid      one instruction retired this cycle
//   commitResult     retired result value
//   commitDest       retired destination register
//   commitPC         PC of the retired instruction
//   commitMispredict retirement caused a pipeline clear
//   traceReady       sink accepts the head entry this cycle
//   clearStats       clears overflow and dropCount
//   traceValid       head entry valid (FIFO not empty)
//   traceResult      head result
//   traceDest        head destination register
//   tracePC          head PC
//   traceMispredict  head mispredict marker
//   traceSeq         head sequence number
//   count            occupied entries, 0..8
//   overflow         sticky: at least one commit was dropped
//   dropCount        number of dropped commits, saturating at all-ones
//
// Handshake: an entry moves from producer to consumer on a rising clk edge
// only when its valid and ready are both high in the preceding cycle. The
// trace side is show-ahead: trace* always reflect the head entry while
// traceValid is high, and traceValid never depends on traceReady. The commit
// side has no back-pressure; a commit that finds the FIFO full, with no pop
// in the same cycle, is dropped and counted.
// ---------------------------------------------------------------------------
module commit_trace_fifo #(
    parameter int WIDTH = 31,
    parameter int REG   = 4,
    parameter int PTR   = 2,
    parameter int SEQ   = 15
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             commitValid,
    input  logic [WIDTH:0]   commitResult,
    input  logic [REG:0]     commitDest,
    input  logic [WIDTH:0]   commitPC,
    input  logic             commitMispredict,
    input  logic             traceReady,
    input  logic             clearStats,
    output logic             traceValid,
    output logic [WIDTH:0]   traceResult,
    output logic [REG:0]     traceDest,
    output logic [WIDTH:0]   tracePC,
    output logic             traceMispredict,
    output logic [SEQ:0]     traceSeq,
    output logic [PTR+1:0]   count,
    output logic             overflow,
    output logic [SEQ:0]     dropCount
);

    localparam int DEPTH = 2 ** (PTR + 1);

    localparam logic [PTR+1:0] PTR_ONE = {{(PTR+1){1'b0}}, 1'b1};
    localparam logic [SEQ:0]   SEQ_ONE = {{SEQ{1'b0}}, 1'b1};
    localparam logic [SEQ:0]   SEQ_MAX = {(SEQ+1){1'b1}};

    // Storage, one array per field.
    logic [WIDTH:0] mem_result     [DEPTH];
    logic [REG:0]   mem_dest       [DEPTH];
    logic [WIDTH:0] mem_pc         [DEPTH];
    logic           mem_mispredict [DEPTH];
    logic [SEQ:0]   mem_seq        [DEPTH];

    // Pointers carry one extra wrap bit above the index so that full and
    // empty can be told apart when the index bits match.
    logic [PTR+1:0] wr_ptr;
    logic [PTR+1:0] rd_ptr;
    logic [PTR:0]   wr_idx;
    logic [PTR:0]   rd_idx;

    logic [SEQ:0]   seq_counter;
    logic           overflow_q;
    logic [SEQ:0]   drop_count_q;

    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    assign wr_idx = wr_ptr[PTR:0];
    assign rd_idx = rd_ptr[PTR:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR+1] != rd_ptr[PTR+1]);

    // A pop in the same cycle frees the slot, so a commit into a full FIFO
    // is still accepted when the sink takes the head.
    assign pop  = !empty && traceReady;
    assign push = commitValid && (!full || pop);
    assign drop = commitValid && full && !pop;

    // Storage, pointers and sequence counter.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            seq_counter <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i]     <= '0;
                mem_dest[i]       <= '0;
                mem_pc[i]         <= '0;
                mem_mispredict[i] <= 1'b0;
                mem_seq[i]        <= '0;
            end
        end else begin
            if (push) begin
                mem_result[wr_idx]     <= commitResult;
                mem_dest[wr_idx]       <= commitDest;
                mem_pc[wr_idx]         <= commitPC;
                mem_mispredict[wr_idx] <= commitMispredict;
                mem_seq[wr_idx]        <= seq_counter;
                wr_ptr                 <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Advances on dropped commits too, leaving a visible gap.
            if (commitValid) begin
                seq_counter <= seq_counter + SEQ_ONE;
            end
        end
    end

    // Overflow statistics. A drop in the same cycle as clearStats wins, so
    // that the dropped event is never lost from the statistics.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (clearStats) begin
                    drop_count_q <= SEQ_ONE;
                end else if (drop_count_q != SEQ_MAX) begin
                    drop_count_q <= drop_count_q + SEQ_ONE;
                end
            end else if (clearStats) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    // Show-ahead outputs straight from the head slot.
    assign traceValid      = !empty;
    assign traceResult     = mem_result[rd_idx];
    assign traceDest       = mem_dest[rd_idx];
    assign tracePC         = mem_pc[rd_idx];
    assign traceMispredict = mem_mispredict[rd_idx];
    assign traceSeq        = mem_seq[rd_idx];

    // Pointer difference is the occupancy, 0..DEPTH, thanks to the wrap bit.
    assign count     = wr_ptr - rd_ptr;
    assign overflow  = overflow_q;
    assign dropCount = drop_count_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

    logic        clk;
    logic        globalReset;
    logic        commitValid;
    logic [31:0] commitResult;
    logic [4:0]  commitDest;
    logic [31:0] commitPC;
    logic        commitMispredict;
    logic        traceReady;
    logic        clearStats;
    logic        traceValid;
    logic [31:0] traceResult;
    logic [4:0]  traceDest;
    logic [31:0] tracePC;
    logic        traceMispredict;
    logic [15:0] traceSeq;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] dropCount;

    int checks;
    int errors;

    logic [31:0] exp_q[$];

    commit_trace_fifo dut (
        .clk              (clk),
        .globalReset      (globalReset),
        .commitValid      (commitValid),
        .commitResult     (commitResult),
        .commitDest       (commitDest),
        .commitPC         (commitPC),
        .commitMispredict (commitMispredict),
        .traceReady       (traceReady),
        .clearStats       (clearStats),
        .traceValid       (traceValid),
        .traceResult      (traceResult),
        .traceDest        (traceDest),
        .tracePC          (tracePC),
        .traceMispredict  (traceMispredict),
        .traceSeq         (traceSeq),
        .count            (count),
        .overflow         (overflow),
        .dropCount        (dropCount)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        globalReset      = 1'b1;
        commitValid      = 1'b0;
        commitResult     = '0;
        commitDest       = '0;
        commitPC         = '0;
        commitMispredict = 1'b0;
        traceReady       = 1'b0;
        clearStats       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        globalReset = 1'b0;
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs
    // are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic v, input logic [31:0] pc,
                              input logic [4:0] dest, input logic [31:0] res,
                              input logic mp);
        commitValid      = v;
        commitPC         = pc;
        commitDest       = dest;
        commitResult     = res;
        commitMispredict = mp;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", traceValid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (dropCount !== 16'h0) begin errors++; $display("FAIL reset_dropcount: got %h expected 0000", dropCount); end
        checks++; if ({tracePC, traceResult, traceDest, traceSeq, traceMispredict} !== '0) begin
            errors++; $display("FAIL reset_data: got pc=%h res=%h dest=%h seq=%h expected all 0", tracePC, traceResult, traceDest, traceSeq);
        end
    endtask

    task automatic test_latency_and_async_reset();
        do_reset();
        set_commit(1'b1, 32'h100, 5'd5, 32'h2A, 1'b0);
        tick();
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", traceValid); end
        checks++; if (tracePC !== 32'h100) begin errors++; $display("FAIL lat_pc: got %h expected 00000100", tracePC); end
        checks++; if (traceDest !== 5'd5) begin errors++; $display("FAIL lat_dest: got %0d expected 5", traceDest); end
        checks++; if (traceResult !== 32'h2A) begin errors++; $display("FAIL lat_result: got %h expected 0000002a", traceResult); end
        checks++; if (traceSeq !== 16'd0) begin errors++; $display("FAIL lat_seq: got %0d expected 0", traceSeq); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL lat_count: got %0d expected 1", count); end
        // Reset asserted mid-cycle must clear immediately.
        #2 globalReset = 1'b1;
        #1;
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", traceValid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", count); end
        checks++; if (tracePC !== 32'h0) begin errors++; $display("FAIL async_rst_pc: got %h expected 0", tracePC); end
        @(negedge clk);
        globalReset = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            set_commit(1'b1, 32'h100 + 32'(4 * i), 5'(i + 1), 32'(i * 3), 1'b0);
            exp_q.push_back(32'h100 + 32'(4 * i));
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_full_count: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
        set_commit(1'b1, 32'h120, 5'd9, 32'h99, 1'b0);
        tick();
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (dropCount !== 16'd1) begin errors++; $display("FAIL ovf_dropcount: got %0d expected 1", dropCount); end
        traceReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid[%0d]: got %b expected 1", i, traceValid); end
            checks++; if (traceSeq !== 16'(i)) begin errors++; $display("FAIL ovf_drain_seq[%0d]: got %0d expected %0d", i, traceSeq, i); end
            checks++; if (tracePC !== exp_q[0]) begin errors++; $display("FAIL ovf_drain_pc[%0d]: got %h expected %h", i, tracePC, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
        end
        traceReady = 1'b0;
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL ovf_drained_empty: got %b expected 0", traceValid); end
        set_commit(1'b1, 32'h124, 5'd0, 32'hDEAD_BEEF, 1'b0);
        tick();
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        checks++; if (traceSeq !== 16'd9) begin errors++; $display("FAIL ovf_gap_seq: got %0d expected 9", traceSeq); end
        checks++; if (traceDest !== 5'd0) begin errors++; $display("FAIL ovf_x0_dest: got %0d expected 0", traceDest); end
        checks++; if (traceResult !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ovf_result: got %h expected deadbeef", traceResult); end
    endtask

    task automatic test_full_with_pop();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            set_commit(1'b1, 32'h100 + 32'(4 * i), 5'd1, 32'h0, 1'b0);
            if (i > 0) exp_q.push_back(32'h100 + 32'(4 * i));
            tick();
        end
        // Simultaneous push into a full FIFO and pop of the head.
        set_commit(1'b1, 32'h200, 5'd2, 32'h55, 1'b0);
        exp_q.push_back(32'h200);
        traceReady = 1'b1;
        tick();
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fwp_count: got %0d expected 8", count); end
        checks++; if (dropCount !== 16'd0) begin errors++; $display("FAIL fwp_dropcount: got %0d expected 0", dropCount); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fwp_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tracePC !== exp_q[0]) begin errors++; $display("FAIL fwp_drain_pc[%0d]: got %h expected %h", i, tracePC, exp_q[0]); end
            checks++; if (traceSeq !== 16'(i + 1)) begin errors++; $display("FAIL fwp_drain_seq[%0d]: got %0d expected %0d", i, traceSeq, i + 1); end
            void'(exp_q.pop_front());
            tick();
        end
        traceReady = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fwp_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        traceReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_commit(1'b1, 32'h300 + 32'(4 * i), 5'(i), 32'(i), 1'b0);
            tick();
            checks++; if (traceSeq !== 16'(i)) begin errors++; $display("FAIL b2b_seq[%0d]: got %0d expected %0d", i, traceSeq, i); end
            checks++; if (count > 4'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected <=1", i, count); end
            checks++; if (tracePC !== 32'h300 + 32'(4 * i)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, tracePC, 32'h300 + 32'(4 * i)); end
        end
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        traceReady = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_final_count: got %0d expected 0", count); end
        checks++; if (dropCount !== 16'd0) begin errors++; $display("FAIL b2b_drops: got %0d expected 0", dropCount); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_saturation_and_clear();
        do_reset();
        set_commit(1'b1, 32'h400, 5'd3, 32'h7, 1'b0);
        repeat (8) tick();
        repeat (65535) tick();
        checks++; if (dropCount !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", dropCount); end
        repeat (5) tick();
        checks++; if (dropCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", dropCount); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL sat_count: got %0d expected 8", count); end
        // Clear coinciding with a drop: the drop wins.
        clearStats = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_drop_overflow: got %b expected 1", overflow); end
        checks++; if (dropCount !== 16'd1) begin errors++; $display("FAIL clr_drop_count: got %0d expected 1", dropCount); end
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        clearStats = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        checks++; if (dropCount !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", dropCount); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL clr_keeps_fifo: got %0d expected 8", count); end
        checks++; if (traceSeq !== 16'd0) begin errors++; $display("FAIL clr_head_seq: got %0d expected 0", traceSeq); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_commit(1'b1, 32'h500 + 32'(4 * i), 5'd7, 32'h1, (i == 2));
            tick();
        end
        set_commit(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        traceReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (traceMispredict !== (i == 2)) begin errors++; $display("FAIL mp_flag[%0d]: got %b expected %b", i, traceMispredict, (i == 2)); end
            tick();
        end
        traceReady = 1'b0;
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL mp_empty: got %b expected 0", traceValid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency_and_async_reset();
        test_overflow();
        test_full_with_pop();
        test_back_to_back();
        test_saturation_and_clear();
        test_mispredict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Sits directly downstream of the CPU top level and consumes its retirement stream: committed result, destination register, committing PC and the mispredict/flush marker.
- Buffers each commit event in a circular FIFO, tags it with a sequence number, and drains events over a valid/ready handshake to a debug/trace sink.
- Counts events lost to overflow so gaps in the trace are detectable by both sequence gaps and a drop counter.

Parameters:
- WIDTH, 31, MSB index of data/PC fields (32-bit)
- REG, 4, MSB index of register-destination field (5-bit)
- PTR, 2, MSB index of FIFO pointer; depth = 2^(PTR+1) = 8 entries
- SEQ, 15, MSB index of sequence number and drop counter (16-bit)

Ports:
- clk  input  1  system clock
- globalReset  input  1  asynchronous, active-high reset
- commitValid  input  1  one instruction retired this cycle
- commitResult  input  WIDTH+1  retired result value
- commitDest  input  REG+1  retired destination register
- commitPC  input  WIDTH+1  PC of retired instruction
- commitMispredict  input  1  retirement caused a pipeline clear (controlFlow[0])
- traceReady  input  1  sink accepts head entry this cycle
- clearStats  input  1  clears overflow flag and drop counter
- traceValid  output  1  head entry valid
- traceResult  output  WIDTH+1  head result
- traceDest  output  REG+1  head destination
- tracePC  output  WIDTH+1  head PC
- traceMispredict  output  1  head mispredict marker
- traceSeq  output  SEQ+1  head sequence number
- count  output  PTR+2  occupied entries, 0..8
- overflow  output  1  sticky: at least one commit dropped
- dropCount  output  SEQ+1  dropped commits, saturating

Behaviour:
- Reset (async, globalReset=1): pointers=0, count=0, seqCounter=0, overflow=0, dropCount=0, traceValid=0. All trace data outputs read 0. Reset mid-drain discards all contents.
- Storage: 8-entry array of {result, dest, PC, mispredict, seq}. Write pointer wrPtr and read pointer rdPtr are PTR+2 bits wide, with the extra wrap bit.
  - empty = (wrPtr == rdPtr)
  - full = same index bits, differing wrap bit
- Show-ahead output: trace* outputs are driven combinationally from array[rdPtr]. traceValid = !empty.
- Latency: a commit sampled at edge N with an empty FIFO appears on traceValid after edge N, in the following cycle.
- Pop: when traceValid && traceReady, rdPtr increments at the clock edge. traceReady while empty has no effect.
- Push: when commitValid && (!full || pop), the entry is written at wrPtr, wrPtr increments, and seq = seqCounter.
- Sequence counter:
  - seqCounter increments on every commitValid, whether accepted or dropped.
  - It wraps from FFFF to 0000.
  - A dropped commit therefore shows as a gap in traceSeq.
- Full with simultaneous pop: the push is accepted and count stays 8. This is required and is not a drop.
- Drop: when commitValid && full && !pop:
  - the entry is discarded;
  - overflow is set to 1;
  - dropCount increments, saturating at FFFF (it holds there, no wrap).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- clearStats: overflow=0 and dropCount=0 at the next edge. If a drop occurs in the same cycle, the drop wins: overflow=1, dropCount=1.
- clearStats does not affect FIFO contents or seqCounter.
- Pointer wrap: indices wrap 7 to 0 and the wrap bit toggles. Ordering must be preserved across the wrap.
- Data fields are stored unmodified: destination x0 and any result value are logged as is.

Test Plan:
- Reset, then commitValid for 1 cycle (PC=0x100, dest=5, result=0x2A) with traceReady=0 -> next cycle traceValid=1, tracePC=0x100, traceDest=5, traceResult=0x2A, traceSeq=0, count=1; assert globalReset mid-cycle -> traceValid=0 immediately, count=0.
- 8 consecutive commits with traceReady=0, then a 9th (PC=0x120) -> count=8, overflow=1, dropCount=1; drain all 8 -> traceSeq 0..7 in order, and the next accepted commit carries traceSeq=9.
- Full FIFO with commitValid=1 and traceReady=1 in the same cycle -> count stays 8, dropCount unchanged, the new entry appears as the 8th item out.
- 20 commits with traceReady=1 every cycle (pointer wrap twice) -> count ≤ 1 throughout, traceSeq 0..19 contiguous, no drops.
- Force 65540 drops -> dropCount=0xFFFF saturated; clearStats with a coincident drop -> overflow=1, dropCount=1.
- commitMispredict=1 on commit 3 of 4 -> only the third drained entry has traceMispredict=1.
